// File: rtl/icb_lsu_master.sv
// ICB load/store initiator: turns one core memory request into an ICB cmd/rsp
// transaction. It builds byte lane masks, replicates write data across lanes,
// and extracts and extends load data.
// Optional feature macro: ICB_WRITE_RSP_EN. When it is defined, writes wait for an ICB response.
// When it is undefined, writes are posted and complete at the cmd handshake.
module icb_lsu_master #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_ready_o,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        icb_cmd_valid,
    input  logic        icb_cmd_ready,
    output logic [31:0] icb_cmd_addr,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_wdata,
    output logic [3:0]  icb_cmd_wmask,
    input  logic        icb_rsp_valid,
    output logic        icb_rsp_ready,
    input  logic        icb_rsp_err,
    input  logic [31:0] icb_rsp_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RSP   = 3'd2,
        S_MERR  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_addr;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_uns;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_latch;
    logic              w_misaligned;
    logic [3:0]        w_lane_wmask;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_load_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic [31:0]       w_rdata_nxt;

    assign mem_ready_o   = (r_state == S_IDLE);
    assign icb_cmd_valid = (r_state == S_CMD);
    assign icb_rsp_ready = (r_state == S_RSP) || (r_state == S_FLUSH);
    assign icb_cmd_addr  = r_addr;
    assign icb_cmd_read  = ~r_we;
    assign icb_cmd_wdata = r_wdata;
    assign icb_cmd_wmask = r_wmask;
    assign mem_done_o    = r_done;
    assign mem_err_o     = r_err;
    assign mem_rdata_o   = r_rdata;

    // Lane mask, replicated write data and alignment check for the incoming request
    always_comb begin
        w_lane_wmask = 4'b0000;
        w_lane_wdata = mem_wdata_i;
        w_misaligned = 1'b0;
        case (mem_size_i)
            2'd0: begin
                w_lane_wmask = 4'b0001 << mem_addr_i[1:0];
                w_lane_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'd1: begin
                w_lane_wmask = 4'b0011 << mem_addr_i[1:0];
                w_lane_wdata = {2{mem_wdata_i[15:0]}};
                w_misaligned = mem_addr_i[0];
            end
            2'd2: begin
                w_lane_wmask = 4'b1111;
                w_misaligned = (mem_addr_i[1:0] != 2'b00);
            end
            default: begin
                w_misaligned = 1'b1;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the response data
    always_comb begin
        w_byte      = icb_rsp_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half      = icb_rsp_rdata[{r_addr[1], 4'b0000} +: 16];
        w_load_data = icb_rsp_rdata;
        case (r_size)
            2'd0:    w_load_data = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_load_data = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = icb_rsp_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (mem_req_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = w_misaligned ? S_MERR : S_CMD;
                end
            end
            S_CMD: begin
                if (icb_cmd_ready) begin
                    w_cnt_nxt = '0;
`ifdef ICB_WRITE_RSP_EN
                    w_state_nxt = S_RSP;
`else
                    if (r_we) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_RSP;
                    end
`endif
                end
            end
            S_RSP: begin
                if (icb_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = icb_rsp_err;
                    if (!r_we) begin
                        w_rdata_nxt = w_load_data;
                    end
                end else if (TO_EN && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = S_FLUSH;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_MERR: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
            end
            S_FLUSH: begin
                // The late response of a timed-out read is drained silently
                if (icb_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latches, held stable for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_latch) begin
            r_addr  <= mem_addr_i;
            r_size  <= mem_size_i;
            r_we    <= mem_we_i;
            r_uns   <= mem_unsigned_i;
            r_wdata <= w_lane_wdata;
            r_wmask <= mem_we_i ? w_lane_wmask : 4'b0000;
        end
    end

    // Completion outputs and response timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_icb_lsu_master.sv
// Directed self-checking bench for icb_lsu_master (default build, TIMEOUT_CYC=8).
module tb_icb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] mem_wdata_i;
    logic        mem_ready_o;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int n_chk;
    int n_err;

    icb_lsu_master #(.TIMEOUT_CYC(8)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_ready_o    (mem_ready_o),
        .mem_done_o     (mem_done_o),
        .mem_rdata_o    (mem_rdata_o),
        .mem_err_o      (mem_err_o),
        .icb_cmd_valid  (icb_cmd_valid),
        .icb_cmd_ready  (icb_cmd_ready),
        .icb_cmd_addr   (icb_cmd_addr),
        .icb_cmd_read   (icb_cmd_read),
        .icb_cmd_wdata  (icb_cmd_wdata),
        .icb_cmd_wmask  (icb_cmd_wmask),
        .icb_rsp_valid  (icb_rsp_valid),
        .icb_rsp_ready  (icb_rsp_ready),
        .icb_rsp_err    (icb_rsp_err),
        .icb_rsp_rdata  (icb_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; the DUT must be idle
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        mem_req_i      = 1'b1;
        mem_we_i       = we;
        mem_addr_i     = addr;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        mem_wdata_i    = wdata;
        step();
        mem_req_i      = 1'b0;
    endtask

    // Latency counted from the accept cycle (accept cycle A, done in cycle A+lat)
    task automatic wait_done(input int max, output int lat, output bit saw_cmd);
        lat     = 1;
        saw_cmd = 1'b0;
        while ((mem_done_o !== 1'b1) && (lat < max)) begin
            if (icb_cmd_valid === 1'b1) saw_cmd = 1'b1;
            step();
            lat++;
        end
        if (mem_done_o !== 1'b1) check_val("done_wait_expired", 32'(mem_done_o), 32'd1);
    endtask

    initial begin
        int lat;
        bit saw;
        n_chk          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        mem_req_i      = 1'b0;
        mem_we_i       = 1'b0;
        mem_addr_i     = '0;
        mem_size_i     = '0;
        mem_unsigned_i = 1'b0;
        mem_wdata_i    = '0;
        icb_cmd_ready  = 1'b1;
        icb_rsp_valid  = 1'b0;
        icb_rsp_err    = 1'b0;
        icb_rsp_rdata  = '0;

        step();
        step();
        check_val("rst_done",      32'(mem_done_o),    32'd0);
        check_val("rst_rdata",     mem_rdata_o,        32'd0);
        check_val("rst_err",       32'(mem_err_o),     32'd0);
        check_val("rst_cmd_valid", 32'(icb_cmd_valid), 32'd0);
        check_val("rst_rsp_ready", 32'(icb_rsp_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check_val("rst_ready", 32'(mem_ready_o), 32'd1);

        // Word store, posted
        issue(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
        check_val("ws_cmd_valid", 32'(icb_cmd_valid), 32'd1);
        check_val("ws_addr",      icb_cmd_addr,       32'h8000_0010);
        check_val("ws_wmask",     32'(icb_cmd_wmask), 32'hF);
        check_val("ws_read",      32'(icb_cmd_read),  32'd0);
        check_val("ws_wdata",     icb_cmd_wdata,      32'hDEAD_BEEF);
        check_val("ws_ready_busy", 32'(mem_ready_o),  32'd0);
        check_val("ws_rsp_ready", 32'(icb_rsp_ready), 32'd0);
        wait_done(30, lat, saw);
        check_val("ws_lat",       32'(lat),           32'd2);
        check_val("ws_err",       32'(mem_err_o),     32'd0);
        check_val("ws_rsp_ready_done", 32'(icb_rsp_ready), 32'd0);
        check_val("ws_ready_done", 32'(mem_ready_o),  32'd1);
        step();
        check_val("ws_done_pulse", 32'(mem_done_o),   32'd0);

        // Byte loads with a slave that answers on the first RSP cycle
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = 32'h8012_3456;
        issue(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0);
        check_val("lbu_read",  32'(icb_cmd_read),  32'd1);
        check_val("lbu_wmask", 32'(icb_cmd_wmask), 32'd0);
        check_val("lbu_addr",  icb_cmd_addr,       32'h8000_0003);
        wait_done(30, lat, saw);
        check_val("lbu_lat",   32'(lat),           32'd3);
        check_val("lbu_rdata", mem_rdata_o,        32'h0000_0080);
        check_val("lbu_err",   32'(mem_err_o),     32'd0);
        step();
        issue(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("lb_lat",    32'(lat),           32'd3);
        check_val("lb_rdata",  mem_rdata_o,        32'hFFFF_FF80);

        // Half and word loads (done cycle is idle, so back-to-back accept)
        issue(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("lh_rdata",  mem_rdata_o,        32'hFFFF_8012);
        issue(1'b0, 32'h8000_0000, 2'd1, 1'b1, 32'h0);
        wait_done(30, lat, saw);
        check_val("lhu_rdata", mem_rdata_o,        32'h0000_3456);
        issue(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("lw_rdata",  mem_rdata_o,        32'h8012_3456);
        icb_rsp_valid = 1'b0;
        step();

        // Half store lane replication
        issue(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234);
        check_val("sh_wdata", icb_cmd_wdata,      32'h1234_1234);
        check_val("sh_wmask", 32'(icb_cmd_wmask), 32'hC);
        wait_done(30, lat, saw);
        check_val("sh_lat",   32'(lat),           32'd2);

        // Misaligned word load and size=3: no bus activity, error completion
        issue(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("mis_lat",   32'(lat),           32'd2);
        check_val("mis_cmd",   32'(saw),           32'd0);
        check_val("mis_err",   32'(mem_err_o),     32'd1);
        check_val("mis_rdata", mem_rdata_o,        32'h8012_3456);
        step();
        issue(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("sz3_lat",   32'(lat),           32'd2);
        check_val("sz3_cmd",   32'(saw),           32'd0);
        check_val("sz3_err",   32'(mem_err_o),     32'd1);

        // Byte store with cmd_ready stalled three cycles
        icb_cmd_ready = 1'b0;
        issue(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_00AB);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_valid", 32'(icb_cmd_valid), 32'd1);
            check_val("stall_addr",  icb_cmd_addr,       32'h8000_0001);
            check_val("stall_wdata", icb_cmd_wdata,      32'hABAB_ABAB);
            check_val("stall_wmask", 32'(icb_cmd_wmask), 32'h2);
            check_val("stall_done",  32'(mem_done_o),    32'd0);
            step();
        end
        icb_cmd_ready = 1'b1;
        step();
        check_val("stall_done_after", 32'(mem_done_o), 32'd1);
        check_val("stall_err",        32'(mem_err_o),  32'd0);

        // Read with error response
        icb_rsp_valid = 1'b1;
        icb_rsp_err   = 1'b1;
        icb_rsp_rdata = 32'h1122_3344;
        issue(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("rerr_lat",   32'(lat),       32'd3);
        check_val("rerr_err",   32'(mem_err_o), 32'd1);
        check_val("rerr_rdata", mem_rdata_o,    32'h1122_3344);
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        step();

        // Timeout: silent slave, then a late response drained in FLUSH
        issue(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0);
        wait_done(30, lat, saw);
        check_val("to_lat",       32'(lat),           32'd10);
        check_val("to_err",       32'(mem_err_o),     32'd1);
        check_val("to_rdata",     mem_rdata_o,        32'h1122_3344);
        check_val("to_ready",     32'(mem_ready_o),   32'd0);
        check_val("to_rsp_ready", 32'(icb_rsp_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("flush_done",  32'(mem_done_o),  32'd0);
            check_val("flush_ready", 32'(mem_ready_o), 32'd0);
        end
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = 32'hCAFE_F00D;
        step();
        icb_rsp_valid = 1'b0;
        check_val("drain_done",  32'(mem_done_o),  32'd0);
        check_val("drain_ready", 32'(mem_ready_o), 32'd1);
        check_val("drain_rdata", mem_rdata_o,      32'h1122_3344);
        issue(1'b1, 32'h8000_0020, 2'd2, 1'b0, 32'h0BAD_CAFE);
        check_val("post_valid", 32'(icb_cmd_valid), 32'd1);
        wait_done(30, lat, saw);
        check_val("post_lat",   32'(lat),           32'd2);
        check_val("post_err",   32'(mem_err_o),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/icb_lsu_master.md
Name: icb_lsu_master

Overview:
- ICB initiator that turns one core load/store request into an ICB cmd/rsp transaction toward memory-side ICB slaves (iram, dram, peripherals).
- Sits between the execute stage's memory request and the ICB bus.
- Core side: it generates byte/half/word lane masks and replicated write data, and sign/zero-extends read data.
- One transaction in flight at a time.

Parameters:
- TIMEOUT_CYC, 255: max cycles to wait in RSP for rsp_valid; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mem_req_i  in  1  core request strobe; sampled only while mem_ready_o=1
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  32  byte address
- mem_size_i  in  2  0=byte, 1=half, 2=word; 3 is treated as misaligned
- mem_unsigned_i  in  1  1=zero-extend load, 0=sign-extend
- mem_wdata_i  in  32  store data, right-aligned
- mem_ready_o  out  1  block can accept a request
- mem_done_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  32  extended load data; held until next completion
- mem_err_o  out  1  error for completed access; valid with mem_done_o
- icb_cmd_valid  out  1  cmd valid
- icb_cmd_ready  in  1  cmd ready
- icb_cmd_addr  out  32  cmd address (full byte address)
- icb_cmd_read  out  1  1=read
- icb_cmd_wdata  out  32  lane-replicated write data
- icb_cmd_wmask  out  4  byte write strobes; 0 for reads
- icb_rsp_valid  in  1  rsp valid
- icb_rsp_ready  out  1  rsp ready
- icb_rsp_err  in  1  rsp error
- icb_rsp_rdata  in  32  rsp read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all request latches cleared.
  - mem_done_o=0, mem_rdata_o=0, mem_err_o=0, icb_cmd_valid=0, icb_rsp_ready=0, timeout counter=0.
  - mem_ready_o=1 once out of reset.
- States: IDLE, CMD, RSP, MERR, FLUSH.
- mem_ready_o = (state==IDLE).
- icb_cmd_valid = (state==CMD).
- icb_rsp_ready = (state==RSP) | (state==FLUSH).
- IDLE, on mem_req_i: latch addr, size, we, unsigned, lane data and mask.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=3) -> MERR.
  - Otherwise -> CMD.
- Lane rules:
  - byte: wmask=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: wmask=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - word: wmask=4'b1111, wdata=wdata.
  - Loads drive wmask=0.
- CMD:
  - addr/read/wdata/wmask stay stable until icb_cmd_ready=1.
  - On handshake, read -> RSP.
  - On handshake, write -> IDLE and completes (posted write; slaves do not respond to writes).
  - Timeout counter cleared on handshake.
- RSP:
  - On icb_rsp_valid, capture rsp_err and extract the lane: byte rdata[8*addr[1:0]+:8], half rdata[16*addr[1]+:16].
  - Extend per mem_unsigned_i; err=rsp_err. -> IDLE and completes.
  - Otherwise the counter increments. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with no rsp -> FLUSH and completes with err=1, rdata unchanged.
- FLUSH: holds icb_rsp_ready=1; the first rsp handshake is discarded -> IDLE. No done is generated. New requests are blocked until then.
- MERR: no bus activity; -> IDLE and completes with err=1, rdata unchanged.
- Completion at cycle E (handshake, timeout or MERR cycle):
  - mem_done_o=1 at E+1 for exactly one cycle, with mem_rdata_o/mem_err_o updated at E+1.
  - State is IDLE at E+1, so a back-to-back request can be accepted at E+1.
- Throughput: latency from request acceptance to done is 2 cycles for a write with cmd_ready=1; 3 cycles for a read with a 1-cycle slave.
- mem_req_i while not IDLE is ignored; the core must hold it until mem_ready_o.

Optional Feature:
- Macro ICB_WRITE_RSP_EN.
- When defined, writes do not complete at cmd handshake; they go to RSP and complete on the rsp handshake.
  - mem_err_o = icb_rsp_err; mem_rdata_o is unchanged.
  - The timeout applies.
- When undefined, writes are posted as described above and rsp channel inputs are ignored outside RSP/FLUSH.

Test Plan:
- Word store, addr 0x8000_0010, wdata 0xDEADBEEF, cmd_ready=1 -> cmd_addr=0x8000_0010, wmask=4'hF, read=0; done 2 cycles after accept, err=0, icb_rsp_ready stays 0.
- Byte load addr 0x8000_0003, rsp_rdata=0x8012_3456: unsigned -> mem_rdata_o=0x0000_0080; signed -> 0xFFFF_FF80. Done 3 cycles after accept with 1-cycle rsp.
- Half store addr 0x8000_0002, wdata 0x0000_1234 -> cmd_wdata=0x1234_1234, wmask=4'b1100.
- Word load addr 0x8000_0002 -> no icb_cmd_valid ever; done+err=1 two cycles after accept.
- cmd_ready held low 3 cycles on a store -> cmd fields constant, done only after handshake. Then rsp_err=1 on a read -> mem_err_o=1 with done.
- TIMEOUT_CYC=8, read, slave silent -> done+err=1 after 8 RSP cycles. A late rsp 5 cycles later is drained in FLUSH without a done, and the next request is accepted afterwards.
